// File: rtl/display_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display frame builder: segment bit positions,
// the 7-segment hex glyph table, the commit/swap FSM state type and the
// default number of digit slots.
// ----------------------------------------------------------------------------
package display_pkg;

    localparam int unsigned DEFAULT_NUM_DIGITS = 9;

    // Bit positions within one 8-bit digit slot (active-high).
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Segments g..a for nibble values 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        WAIT_SYNC,
        SWAP
    } fsm_state_e;

endpackage

// File: rtl/display_frame_builder_if.sv
// ----------------------------------------------------------------------------
// display_frame_builder_if
// Digit write channel of the display frame builder.
//   wr_valid  : write request (master -> slave)
//   wr_ready  : write accepted when wr_valid & wr_ready (slave -> master)
//   wr_digit  : target slot index
//   wr_raw    : 1 = wr_data holds raw segments, 0 = hex nibble + dp
//   wr_data   : raw segments, or [3:0] nibble and [4] decimal point
//   wr_err    : one-cycle pulse after an accepted out-of-range write
// ----------------------------------------------------------------------------
interface display_frame_builder_if;

    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_digit;
    logic       wr_raw;
    logic [7:0] wr_data;
    logic       wr_err;

    modport master (
        output wr_valid,
        output wr_digit,
        output wr_raw,
        output wr_data,
        input  wr_ready,
        input  wr_err
    );

    modport slave (
        input  wr_valid,
        input  wr_digit,
        input  wr_raw,
        input  wr_data,
        output wr_ready,
        output wr_err
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// ----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex-to-7-segment glyph decoder.
//   i_nibble : hex value 0..F
//   i_dp     : decimal point
//   o_seg    : segments a..g in bits 0..6, dp in bit 7, active-high
// ----------------------------------------------------------------------------
module seg7_hex_decode
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg               = '0;
        o_seg[SEG_G:SEG_A]  = HEX_SEG[i_nibble];
        o_seg[SEG_DP]       = i_dp;
    end

endmodule

// File: rtl/display_frame_builder.sv
// ----------------------------------------------------------------------------
// display_frame_builder
// Double-buffered frame store for a multiplexed 7-segment display. Digit
// writes go through a two-stage pipeline (decode register, then back buffer).
// A commit publishes the back buffer to the front buffer on the next
// frame_sync so the serial shifter never sees a half-updated frame.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   wr            : digit write channel (display_frame_builder_if.slave)
//   commit        : single-cycle request to publish the back buffer
//   frame_sync    : single-cycle frame-boundary pulse
//   blink_mask    : per-digit blink enable (only with DISPLAY_BLINK_EN)
//   display_bits  : front buffer, digit d in bits [8d+7:8d]
//   pending       : commit captured, swap not yet done
//
// Optional feature: define DISPLAY_BLINK_EN to add blink_mask and a blink
// phase that blanks masked digits every other BLINK_DIV frame_sync pulses.
// ----------------------------------------------------------------------------
module display_frame_builder
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEFAULT_NUM_DIGITS,
    parameter int unsigned BLINK_DIV  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    display_frame_builder_if.slave  wr,
    input  logic                    commit,
    input  logic                    frame_sync,
`ifdef DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [8*NUM_DIGITS-1:0] display_bits,
    output logic                    pending
);

    // Elaboration-time parameter sanity: slot index is 4 bits wide.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
        $error("NUM_DIGITS must be in 1..16");
    end
    if (BLINK_DIV < 1 || BLINK_DIV > 65536) begin : g_bad_blink_div
        $error("BLINK_DIV must be in 1..65536");
    end

    // ------------------------------------------------------------------------
    // Write pipeline
    // ------------------------------------------------------------------------
    logic                    w_wr_ready;
    logic                    w_accept;
    logic                    w_out_of_range;
    logic [7:0]              w_hex_seg;

    logic                    r_dec_valid;
    logic [3:0]              r_dec_digit;
    logic [7:0]              r_dec_seg;
    logic                    r_wr_err;
    logic [8*NUM_DIGITS-1:0] r_back;

    fsm_state_e              r_state;
    logic                    r_wr_ready;
    logic                    r_pending;
    logic [8*NUM_DIGITS-1:0] r_front;

    // r_wr_ready resets to 1 so the first cycle after rst falls is ready;
    // the rst gate keeps wr_ready low while reset is held.
    assign w_wr_ready     = r_wr_ready & ~rst;
    assign w_accept       = wr.wr_valid & w_wr_ready;
    assign w_out_of_range = 32'(wr.wr_digit) >= NUM_DIGITS;

    assign wr.wr_ready    = w_wr_ready;
    assign wr.wr_err      = r_wr_err;
    assign pending        = r_pending;

    seg7_hex_decode u_hex_decode (
        .i_nibble (wr.wr_data[3:0]),
        .i_dp     (wr.wr_data[4]),
        .o_seg    (w_hex_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec_valid <= 1'b0;
            r_dec_digit <= '0;
            r_dec_seg   <= '0;
            r_wr_err    <= 1'b0;
            r_back      <= '0;
        end else begin
            // Out-of-range writes still occupy the pipeline so a same-cycle
            // commit drains them like any other write; they just never match
            // a slot below.
            r_dec_valid <= w_accept;
            r_wr_err    <= w_accept & w_out_of_range;
            if (w_accept) begin
                r_dec_digit <= wr.wr_digit;
                r_dec_seg   <= wr.wr_raw ? wr.wr_data : w_hex_seg;
            end
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (r_dec_valid && r_dec_digit == 4'(d)) begin
                    r_back[8*d +: 8] <= r_dec_seg;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Commit / swap FSM
    // ------------------------------------------------------------------------
`ifdef DISPLAY_BLINK_EN
    logic [NUM_DIGITS-1:0] r_mask;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wr_ready <= 1'b1;
            r_pending  <= 1'b0;
            r_front    <= '0;
`ifdef DISPLAY_BLINK_EN
            r_mask     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (commit) begin
                        r_wr_ready <= 1'b0;
                        r_pending  <= 1'b1;
                        // A write accepted this same cycle is still in flight.
                        r_state    <= (r_dec_valid || w_accept) ? DRAIN : WAIT_SYNC;
                    end
                end
                DRAIN: begin
                    if (!r_dec_valid) begin
                        r_state <= WAIT_SYNC;
                    end
                end
                WAIT_SYNC: begin
                    if (frame_sync) begin
                        r_pending <= 1'b0;
                        r_state   <= SWAP;
                    end
                end
                SWAP: begin
                    r_front    <= r_back;
`ifdef DISPLAY_BLINK_EN
                    r_mask     <= blink_mask;
`endif
                    r_wr_ready <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
`ifdef DISPLAY_BLINK_EN
    logic [15:0] r_blink_cnt;
    logic        r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (frame_sync) begin
            if (r_blink_cnt == 16'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        display_bits = r_front;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_phase && r_mask[d]) begin
                display_bits[8*d +: 8] = 8'h00;
            end
        end
    end
`else
    assign display_bits = r_front;
`endif

endmodule

// File: tb/tb_display_frame_builder.sv
// ----------------------------------------------------------------------------
// tb_display_frame_builder
// Directed self-checking bench for display_frame_builder (NUM_DIGITS = 9,
// BLINK_DIV = 8). Blink checks run only when DISPLAY_BLINK_EN is defined.
// ----------------------------------------------------------------------------
module tb_display_frame_builder;
    import display_pkg::*;

    localparam int unsigned ND = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          commit;
    logic          frame_sync;
    logic [8*ND-1:0] display_bits;
    logic          pending;
`ifdef DISPLAY_BLINK_EN
    logic [ND-1:0] blink_mask;
`endif

    display_frame_builder_if wr_if ();

    display_frame_builder #(
        .NUM_DIGITS (ND),
        .BLINK_DIV  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr_if.slave),
        .commit       (commit),
        .frame_sync   (frame_sync),
`ifdef DISPLAY_BLINK_EN
        .blink_mask   (blink_mask),
`endif
        .display_bits (display_bits),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] digit, input logic raw, input logic [7:0] data);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_digit = digit;
        wr_if.wr_raw   = raw;
        wr_if.wr_data  = data;
        tick();
        wr_if.wr_valid = 1'b0;
    endtask

    // commit, let any write drain, then one frame_sync and the SWAP cycle.
    task automatic swap_frame();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        commit         = 1'b0;
        frame_sync     = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_digit = '0;
        wr_if.wr_raw   = 1'b0;
        wr_if.wr_data  = '0;
`ifdef DISPLAY_BLINK_EN
        blink_mask     = '0;
`endif

        // Reset state
        tick();
        tick();
        check("rst_display", display_bits, '0);
        check("rst_pending", pending, 1'b0);
        check("rst_wr_ready", wr_if.wr_ready, 1'b0);
        check("rst_wr_err", wr_if.wr_err, 1'b0);
        check("rst_state", dut.r_state, IDLE);
        rst = 1'b0;
        #1;
        check("ready_after_rst", wr_if.wr_ready, 1'b1);

        // Slot 0 hex 5 with dp -> ED
        write(4'd0, 1'b0, 8'h15);
        tick();
        check("front_held_before_swap", display_bits, '0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("wait_pending", pending, 1'b1);
        check("wait_ready", wr_if.wr_ready, 1'b0);
        check("wait_state", dut.r_state, WAIT_SYNC);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("swap_state", dut.r_state, SWAP);
        check("swap_pending", pending, 1'b0);
        check("swap_display_unchanged", display_bits, '0);
        tick();
        check("hex5_dp", display_bits, 72'h00_00_00_00_00_00_00_00_ED);
        check("ready_after_swap", wr_if.wr_ready, 1'b1);

        // Slot 8 raw A5, commit while still in flight -> DRAIN
        write(4'd8, 1'b1, 8'hA5);
        check("no_err_in_range", wr_if.wr_err, 1'b0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("drain_state", dut.r_state, DRAIN);
        check("drain_ready", wr_if.wr_ready, 1'b0);
        check("drain_pending", pending, 1'b1);
        tick();
        check("drain_to_wait", dut.r_state, WAIT_SYNC);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        check("raw_slot8", display_bits, 72'hA5_00_00_00_00_00_00_00_ED);

        // Out-of-range writes
        write(4'd12, 1'b1, 8'hFF);
        check("err_slot12_pulse", wr_if.wr_err, 1'b1);
        tick();
        check("err_slot12_one_cycle", wr_if.wr_err, 1'b0);
        write(4'd9, 1'b1, 8'hFF);
        check("err_slot9_boundary", wr_if.wr_err, 1'b1);
        tick();
        swap_frame();
        check("err_buffer_unchanged", display_bits, 72'hA5_00_00_00_00_00_00_00_ED);

        // commit with frame_sync in the same cycle, commit during WAIT_SYNC
        write(4'd1, 1'b0, 8'h03);
        tick();
        commit     = 1'b1;
        frame_sync = 1'b1;
        tick();
        commit     = 1'b0;
        frame_sync = 1'b0;
        check("same_cycle_no_swap_state", dut.r_state, WAIT_SYNC);
        tick();
        tick();
        check("same_cycle_no_swap_disp", display_bits, 72'hA5_00_00_00_00_00_00_00_ED);
        commit         = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_digit = 4'd2;
        wr_if.wr_raw   = 1'b1;
        wr_if.wr_data  = 8'h7E;
        tick();
        commit = 1'b0;
        check("commit_in_wait_ignored", dut.r_state, WAIT_SYNC);
        check("commit_in_wait_pending", pending, 1'b1);
        tick();
        wr_if.wr_valid = 1'b0;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        check("next_sync_swaps", display_bits, 72'hA5_00_00_00_00_00_00_4F_ED);
        check("ready_after_swap2", wr_if.wr_ready, 1'b1);

        // Reset during WAIT_SYNC
        write(4'd3, 1'b1, 8'h11);
        tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("pre_rst_pending", pending, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_pending", pending, 1'b0);
        check("mid_rst_display", display_bits, '0);
        check("mid_rst_ready", wr_if.wr_ready, 1'b0);
        tick();
        rst = 1'b0;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        check("post_rst_no_swap", display_bits, '0);
        check("post_rst_state", dut.r_state, IDLE);
        swap_frame();
        check("post_rst_back_cleared", display_bits, '0);

        // Hex table sweep
        for (int i = 0; i < 8; i++) begin
            write(4'(i), 1'b0, 8'(i));
        end
        swap_frame();
        check("hex_0_7", display_bits, 72'h00_07_7D_6D_66_4F_5B_06_3F);
        for (int i = 0; i < 8; i++) begin
            write(4'(i), 1'b0, 8'(8 + i));
        end
        write(4'd8, 1'b0, 8'h1F);
        swap_frame();
        check("hex_8_f_dp", display_bits, 72'hF1_71_79_5E_39_7C_77_6F_7F);

`ifdef DISPLAY_BLINK_EN
        // Blink: digit 0 masked, BLINK_DIV = 8
        rst = 1'b1;
        tick();
        rst = 1'b0;
        write(4'd0, 1'b0, 8'h15);
        tick();
        blink_mask = 9'h001;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        frame_sync = 1'b1;    // pulse 0 triggers the swap
        tick();
        frame_sync = 1'b0;
        tick();
        for (int k = 1; k < 24; k++) begin
            frame_sync = 1'b1;
            #1;
            check($sformatf("blink_pulse_%0d", k), display_bits[7:0],
                  (k >= 8 && k < 16) ? 8'h00 : 8'hED);
            tick();
            frame_sync = 1'b0;
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
